mc_ctrl: RTL

MC_CTRL -- requirements
Module: mc_ctrl

---
 rtl/mc_pkg.sv | 57 +++++
 rtl/mc_decode.sv | 36 +++
 rtl/mc_ctrl.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/mc_pkg.sv
// rtl/mc_pkg.sv - shared encodings for the multi-cycle controller
package mc_pkg;

  localparam logic [2:0] S_FETCH  = 3'd0;
  localparam logic [2:0] S_DECODE = 3'd1;
  localparam logic [2:0] S_EXE    = 3'd2;
  localparam logic [2:0] S_MEM    = 3'd3;
  localparam logic [2:0] S_WB     = 3'd4;
  localparam logic [2:0] S_MEMWB  = 3'd5;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LB    = 6'h20;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SB    = 6'h28;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] F_JR     = 6'h08;
  localparam logic [5:0] F_ADDU   = 6'h21;
  localparam logic [5:0] F_SUBU   = 6'h23;
  localparam logic [5:0] F_SLT    = 6'h2A;

  localparam logic [1:0] NPC_PC4    = 2'b00;
  localparam logic [1:0] NPC_BRANCH = 2'b01;
  localparam logic [1:0] NPC_JUMP   = 2'b10;
  localparam logic [1:0] NPC_JR     = 2'b11;

  localparam logic [1:0] GPR_RD  = 2'b00;
  localparam logic [1:0] GPR_RT  = 2'b01;
  localparam logic [1:0] GPR_RA  = 2'b10;
  localparam logic [1:0] GPR_R30 = 2'b11;

  localparam logic [1:0] M2R_ALU = 2'b00;
  localparam logic [1:0] M2R_MEM = 2'b01;
  localparam logic [1:0] M2R_PC  = 2'b10;
  localparam logic [1:0] M2R_ONE = 2'b11;

  localparam logic [1:0] EXT_ZERO = 2'b00;
  localparam logic [1:0] EXT_SIGN = 2'b01;
  localparam logic [1:0] EXT_LUI  = 2'b10;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_OR  = 2'b10;
  localparam logic [1:0] ALU_SLT = 2'b11;

  typedef enum logic [3:0] {
    I_ILL, I_ADDU, I_SUBU, I_SLT, I_JR, I_ORI, I_LUI, I_ADDI,
    I_LW, I_SW, I_LB, I_SB, I_BEQ, I_J, I_JAL
  } instr_e;

endpackage

// File: rtl/mc_decode.sv
// rtl/mc_decode.sv - combinational op/funct to instruction class decode
module mc_decode
  import mc_pkg::*;
(
  input  logic [5:0] op,
  input  logic [5:0] funct,
  output instr_e     instr
);

  always_comb begin
    instr = I_ILL;
    case (op)
      OP_RTYPE: begin
        case (funct)
          F_ADDU:  instr = I_ADDU;
          F_SUBU:  instr = I_SUBU;
          F_SLT:   instr = I_SLT;
          F_JR:    instr = I_JR;
          default: instr = I_ILL;
        endcase
      end
      OP_J:    instr = I_J;
      OP_JAL:  instr = I_JAL;
      OP_BEQ:  instr = I_BEQ;
      OP_ADDI: instr = I_ADDI;
      OP_ORI:  instr = I_ORI;
      OP_LUI:  instr = I_LUI;
      OP_LB:   instr = I_LB;
      OP_LW:   instr = I_LW;
      OP_SB:   instr = I_SB;
      OP_SW:   instr = I_SW;
      default: instr = I_ILL;
    endcase
  end

endmodule

// File: rtl/mc_ctrl.sv
// rtl/mc_ctrl.sv - multi-cycle MIPS-subset controller FSM with perf counters
// MC_CTRL_PERF_EN enables the cyc_cnt/ret_cnt counters; otherwise they read 0.
module mc_ctrl
  import mc_pkg::*;
#(
  parameter int CNT_W  = 32,
  parameter int MEM_HS = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [5:0]       op,
  input  logic [5:0]       funct,
  input  logic             zero,
  input  logic             overflow,
  input  logic             im_ack,
  input  logic             dm_ack,
  output logic             mem_req,
  output logic             PCWr,
  output logic             IRWr,
  output logic             DMWr,
  output logic             GPRWr,
  output logic             ALUsrc,
  output logic             ALUsign,
  output logic             byteOp,
  output logic [1:0]       M2Rsel,
  output logic [1:0]       GPRsel,
  output logic [1:0]       ExtOp,
  output logic [1:0]       NPCop,
  output logic [1:0]       ALUop,
  output logic [2:0]       state,
  output logic             illegal,
  output logic [CNT_W-1:0] cyc_cnt,
  output logic [CNT_W-1:0] ret_cnt
);

  instr_e     instr;
  logic [2:0] state_q, state_nxt;
  logic       im_ok, dm_ok;
  logic       pc_wr, ir_wr, dm_wr, gpr_wr, ill;
  logic       is_store, is_load;

  mc_decode u_decode (
    .op    (op),
    .funct (funct),
    .instr (instr)
  );

  assign im_ok    = (MEM_HS != 0) ? im_ack : 1'b1;
  assign dm_ok    = (MEM_HS != 0) ? dm_ack : 1'b1;
  assign is_store = (instr == I_SW) || (instr == I_SB);
  assign is_load  = (instr == I_LW) || (instr == I_LB);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= S_FETCH;
    else      state_q <= state_nxt;
  end

  always_comb begin
    state_nxt = state_q;
    mem_req   = 1'b0;
    pc_wr     = 1'b0;
    ir_wr     = 1'b0;
    dm_wr     = 1'b0;
    gpr_wr    = 1'b0;
    ill       = 1'b0;
    ALUsrc    = 1'b0;
    ALUsign   = 1'b0;
    byteOp    = 1'b0;
    M2Rsel    = M2R_ALU;
    GPRsel    = GPR_RD;
    ExtOp     = EXT_ZERO;
    NPCop     = NPC_PC4;
    ALUop     = ALU_ADD;
    case (state_q)
      S_FETCH: begin
        mem_req = 1'b1;
        if (im_ok) begin
          ir_wr     = 1'b1;
          pc_wr     = 1'b1;
          state_nxt = S_DECODE;
        end
      end
      S_DECODE: begin
        case (instr)
          I_J: begin
            pc_wr = 1'b1; NPCop = NPC_JUMP; state_nxt = S_FETCH;
          end
          I_JAL: begin
            pc_wr = 1'b1; NPCop = NPC_JUMP; state_nxt = S_FETCH;
            gpr_wr = 1'b1; GPRsel = GPR_RA; M2Rsel = M2R_PC;
          end
          I_JR: begin
            pc_wr = 1'b1; NPCop = NPC_JR; state_nxt = S_FETCH;
          end
          I_ILL: begin
            ill = 1'b1; state_nxt = S_FETCH;
          end
          default: state_nxt = S_EXE;
        endcase
      end
      S_EXE: begin
        case (instr)
          I_ADDU: begin ALUop = ALU_ADD; state_nxt = S_WB; end
          I_SUBU: begin ALUop = ALU_SUB; state_nxt = S_WB; end
          I_SLT:  begin ALUop = ALU_SLT; ALUsign = 1'b1; state_nxt = S_WB; end
          I_ORI:  begin ALUsrc = 1'b1; ExtOp = EXT_ZERO; ALUop = ALU_OR; state_nxt = S_WB; end
          I_LUI:  begin ALUsrc = 1'b1; ExtOp = EXT_LUI; state_nxt = S_WB; end
          I_ADDI: begin ALUsrc = 1'b1; ExtOp = EXT_SIGN; ALUsign = 1'b1; state_nxt = S_WB; end
          I_LW, I_SW, I_LB, I_SB: begin
            ALUsrc = 1'b1; ExtOp = EXT_SIGN; state_nxt = S_MEM;
          end
          I_BEQ: begin
            ALUop = ALU_SUB; pc_wr = zero; NPCop = NPC_BRANCH; state_nxt = S_FETCH;
          end
          default: state_nxt = S_FETCH;
        endcase
      end
      S_MEM: begin
        mem_req = 1'b1;
        byteOp  = (instr == I_LB) || (instr == I_SB);
        if (is_store) begin
          dm_wr = 1'b1;
          if (dm_ok) state_nxt = S_FETCH;
        end else if (is_load) begin
          if (dm_ok) state_nxt = S_MEMWB;
        end else begin
          state_nxt = S_FETCH;
        end
      end
      S_WB: begin
        gpr_wr    = 1'b1;
        state_nxt = S_FETCH;
        GPRsel    = (instr == I_ADDU || instr == I_SUBU || instr == I_SLT) ? GPR_RD : GPR_RT;
        // An overflowing addi reports through $30 instead of writing rt.
        if (instr == I_ADDI && overflow) begin
          GPRsel = GPR_R30;
          M2Rsel = M2R_ONE;
        end
      end
      S_MEMWB: begin
        gpr_wr = 1'b1; GPRsel = GPR_RT; M2Rsel = M2R_MEM; state_nxt = S_FETCH;
      end
      default: state_nxt = S_FETCH;
    endcase
  end

  assign state   = state_q;
  assign PCWr    = pc_wr  & rst;
  assign IRWr    = ir_wr  & rst;
  assign DMWr    = dm_wr  & rst;
  assign GPRWr   = gpr_wr & rst;
  assign illegal = ill    & rst;

`ifdef MC_CTRL_PERF_EN
  logic retire;
  // Any return to FETCH other than an illegal decode completes an instruction.
  assign retire = (state_q != S_FETCH) && (state_nxt == S_FETCH) && !ill;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cyc_cnt <= '0;
      ret_cnt <= '0;
    end else begin
      cyc_cnt <= cyc_cnt + 1'b1;
      if (retire) ret_cnt <= ret_cnt + 1'b1;
    end
  end
`else
  assign cyc_cnt = '0;
  assign ret_cnt = '0;
`endif

endmodule
